// File: rtl/link_arb_pkg.sv
// Shared types and helpers for the modem byte-link arbiter.
package link_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam int DEF_GAP_TICKS     = 2;
   localparam int DEF_TIMEOUT_TICKS = 64;

   // Round-robin search over up to 8 candidates starting at ptr.
   // Returns {found, index}.
   function automatic logic [3:0] rr_pick(input logic [7:0] cand,
                                          input logic [2:0] ptr,
                                          input int         n);
      logic [3:0] r;
      logic [3:0] idx;
      r = 4'd0;
      // Walk from the farthest offset down so the nearest hit wins.
      for (int k = 7; k >= 0; k--) begin
         if (k < n) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'(n)) idx = idx - 4'(n);
            if (cand[idx[2:0]]) r = {1'b1, idx[2:0]};
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/link_tick_gen.sv
// Free-running byte-period divider: one-cycle tick every div_i+1 clocks.
module link_tick_gen #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DIV_W-1:0] div_i,
   output logic             tick_o
);

   logic [DIV_W-1:0] cnt;

   // >= so that lowering div_i mid-count still yields a prompt tick.
   assign tick_o = (cnt >= div_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      cnt <= '0;
      else if (tick_o) cnt <= '0;
      else             cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/link_arbiter.sv
// Message-granular round-robin arbiter for the shared modem byte link.
// Optional stall timeout enabled with `define LINK_ARB_TIMEOUT_EN.
module link_arbiter
   import link_arb_pkg::*;
#(
   parameter int NREQ          = 2,
   parameter int DIV_W         = 8,
   parameter int GAP_TICKS     = DEF_GAP_TICKS,
   parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DIV_W-1:0]  div_i,
   input  logic [NREQ-1:0]   req_valid_i,
   input  logic [NREQ-1:0]   req_begin_i,
   input  logic [NREQ-1:0]   req_end_i,
   input  logic [8*NREQ-1:0] req_byte_i,
   output logic [NREQ-1:0]   req_ready_o,
   output logic [7:0]        byte_o,
   output logic              begin_o,
   output logic              valid_o,
   output logic              end_o,
   output logic              strobe_o,
   output logic [NREQ-1:0]   grant_o,
   output logic              busy_o,
   output logic              clk_req_o,
   output logic              abort_o
);

   state_t          state_q, state_d;
   logic [NREQ-1:0] grant_q;
   logic [2:0]      owner, rr_ptr;
   logic [3:0]      gap_cnt;
   logic            tick, in_xfer, accept, last, tmo, release_link, gap_done;
   logic [7:0]      cand, valid8, begin8, end8;
   logic [63:0]     bytes64;
   logic [3:0]      pick;

   link_tick_gen #(.DIV_W(DIV_W)) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .div_i  (div_i),
      .tick_o (tick)
   );

   // Zero-extend so a 3-bit owner index is always in range.
   assign valid8  = 8'(req_valid_i);
   assign begin8  = 8'(req_begin_i);
   assign end8    = 8'(req_end_i);
   assign bytes64 = 64'(req_byte_i);
   assign cand    = 8'(req_valid_i & req_begin_i);
   assign pick    = rr_pick(cand, rr_ptr, NREQ);

   assign in_xfer      = (state_q == XFER);
   assign accept       = in_xfer & tick & valid8[owner];
   assign last         = accept & end8[owner];
   assign gap_done     = (gap_cnt == 4'(GAP_TICKS - 1));
   assign release_link = last | tmo;

`ifdef LINK_ARB_TIMEOUT_EN
   localparam int SW = $clog2(TIMEOUT_TICKS + 1);
   logic [SW-1:0] stall_cnt;

   assign tmo = in_xfer & tick & ~valid8[owner] & (stall_cnt == SW'(TIMEOUT_TICKS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      stall_cnt <= '0;
      else if (!in_xfer || accept || tmo) stall_cnt <= '0;
      else if (tick)                   stall_cnt <= stall_cnt + 1'b1;
   end
`else
   assign tmo = 1'b0;
`endif

   assign abort_o     = tmo;
   assign req_ready_o = grant_q & {NREQ{accept}};
   assign strobe_o    = accept;
   assign byte_o      = in_xfer ? bytes64[{owner, 3'b000} +: 8] : 8'd0;
   assign begin_o     = in_xfer & begin8[owner];
   assign valid_o     = in_xfer & valid8[owner];
   assign end_o       = in_xfer & end8[owner];
   assign grant_o     = grant_q;
   assign busy_o      = (state_q != IDLE);
   assign clk_req_o   = busy_o | (|req_valid_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick[3]) state_d = XFER;
         XFER:    if (release_link) state_d = (GAP_TICKS > 0) ? GAP : IDLE;
         GAP:     if (tick && gap_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q <= '0;
         owner   <= '0;
         rr_ptr  <= '0;
         gap_cnt <= '0;
      end else begin
         case (state_q)
            IDLE: if (pick[3]) begin
               owner   <= pick[2:0];
               grant_q <= NREQ'(1) << pick[2:0];
            end
            XFER: if (release_link) begin
               grant_q <= '0;
               gap_cnt <= '0;
               rr_ptr  <= (owner == 3'(NREQ - 1)) ? 3'd0 : owner + 3'd1;
            end
            GAP: if (tick) gap_cnt <= gap_done ? 4'd0 : gap_cnt + 4'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_link_arbiter.sv
// Directed self-checking bench for link_arbiter (NREQ=2, GAP_TICKS=2).
module tb_link_arbiter;

`ifdef LINK_ARB_TIMEOUT_EN
   localparam int TO_TICKS = 4;
   localparam int STALL    = 3;
`else
   localparam int TO_TICKS = 64;
   localparam int STALL    = 5;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  div;
   logic [1:0]  valid, begin_v, end_v;
   logic [15:0] bytes;
   logic [1:0]  req_ready, grant;
   logic [7:0]  byte_o;
   logic        begin_o, valid_o, end_o, strobe, busy, clk_req, abort;

   int n_chk = 0;
   int n_fail = 0;
   int w;

   always #5 clk = ~clk;

   link_arbiter #(.NREQ(2), .DIV_W(8), .GAP_TICKS(2), .TIMEOUT_TICKS(TO_TICKS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .div_i       (div),
      .req_valid_i (valid),
      .req_begin_i (begin_v),
      .req_end_i   (end_v),
      .req_byte_i  (bytes),
      .req_ready_o (req_ready),
      .byte_o      (byte_o),
      .begin_o     (begin_o),
      .valid_o     (valid_o),
      .end_o       (end_o),
      .strobe_o    (strobe),
      .grant_o     (grant),
      .busy_o      (busy),
      .clk_req_o   (clk_req),
      .abort_o     (abort)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr_req(input int r);
      valid[r] = 1'b0; begin_v[r] = 1'b0; end_v[r] = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      valid = '0; begin_v = '0; end_v = '0; bytes = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Present one byte for requester r and wait for its accept pulse.
   task automatic beat(input int r, input logic [7:0] b, input logic bg, input logic en,
                       output int waited);
      valid[r] = 1'b1; begin_v[r] = bg; end_v[r] = en; bytes[r*8 +: 8] = b;
      waited = 0;
      #1;
      while (!req_ready[r] && waited < 200) begin
         @(negedge clk); #1; waited++;
      end
      chk("beat_ready", req_ready[r], 1'b1);
      chk("beat_out", {strobe, valid_o, begin_o, end_o, byte_o, grant},
                      {1'b1, 1'b1, bg, en, b, 2'(1 << r)});
      @(negedge clk);
      clr_req(r);
   endtask

   task automatic wait_grant(output int waited);
      waited = 0;
      #1;
      while (grant == 2'b00 && waited < 50) begin
         @(negedge clk); #1; waited++;
      end
   endtask

   initial begin
      div = 8'd3; valid = '0; begin_v = '0; end_v = '0; bytes = '0;
      #1;
      chk("reset_outs", {req_ready, byte_o, begin_o, valid_o, end_o, strobe, grant, busy, clk_req, abort}, '0);
      @(negedge clk); rst_n = 1'b1; @(negedge clk);

      // 1: single requester, div=3, "AbC"
      beat(0, 8'h41, 1'b1, 1'b0, w);
      beat(0, 8'h62, 1'b0, 1'b0, w);
      chk("t1_period_b", w, 3);
      beat(0, 8'h43, 1'b0, 1'b1, w);
      chk("t1_period_C", w, 3);
      #1;
      chk("t1_gap", {busy, grant, valid_o}, {1'b1, 2'b00, 1'b0});
      repeat (7) @(negedge clk);
      #1 chk("t1_gap_end_busy", busy, 1'b1);
      @(negedge clk);
      #1 chk("t1_idle", busy, 1'b0);

      // 2: simultaneous begin after reset, round-robin fairness
      do_reset();
      div = 8'd0;
      valid = 2'b11; begin_v = 2'b11; end_v = 2'b11; bytes = 16'h2211;
      wait_grant(w);
      chk("t2_first", {grant, req_ready, byte_o}, {2'b01, 2'b01, 8'h11});
      @(negedge clk);
      wait_grant(w);
      chk("t2_second", {grant, req_ready, byte_o}, {2'b10, 2'b10, 8'h22});
      @(negedge clk);
      clr_req(1);
      wait_grant(w);
      chk("t2_third", grant, 2'b01);
      @(negedge clk);
      clr_req(0);

      // 3: div=0, one-byte message on req1, then rr_ptr wraps to 0
      do_reset();
      div = 8'd0;
      beat(1, 8'h5A, 1'b1, 1'b1, w);
      chk("t3_latency", w, 1);
      #1 chk("t3_released", grant, 2'b00);
      valid = 2'b11; begin_v = 2'b11; end_v = 2'b11;
      wait_grant(w);
      chk("t3_rr_ptr0", grant, 2'b01);
      @(negedge clk);
      clr_req(0); clr_req(1);

      // 4: owner stalls mid-message
      do_reset();
      div = 8'd1;
      beat(0, 8'h31, 1'b1, 1'b0, w);
      for (int i = 0; i < 2 * STALL; i++) begin
         #1 chk("t4_stall", {strobe, grant, abort}, {1'b0, 2'b01, 1'b0});
         @(negedge clk);
      end
      beat(0, 8'h32, 1'b0, 1'b1, w);

`ifdef LINK_ARB_TIMEOUT_EN
      // 5: stall timeout hands the link to the waiting requester
      do_reset();
      div = 8'd0;
      beat(0, 8'h41, 1'b1, 1'b0, w);
      valid[1] = 1'b1; begin_v[1] = 1'b1; end_v[1] = 1'b1; bytes[15:8] = 8'h42;
      w = 0;
      #1;
      while (!abort && w < 100) begin
         @(negedge clk); #1; w++;
      end
      chk("t5_abort_tick", w, 3);
      chk("t5_abort_grant", {abort, strobe, grant}, {1'b1, 1'b0, 2'b01});
      @(negedge clk);
      #1 chk("t5_abort_pulse", abort, 1'b0);
      wait_grant(w);
      chk("t5_new_owner", {grant, byte_o}, {2'b10, 8'h42});
      @(negedge clk);
      clr_req(1);
`endif

      // 6: reset mid-XFER releases the link asynchronously
      do_reset();
      div = 8'd3;
      beat(0, 8'h01, 1'b1, 1'b1, w);
      valid[1] = 1'b1; begin_v[1] = 1'b1; bytes[15:8] = 8'h77;
      wait_grant(w);
      chk("t6_owner", grant, 2'b10);
      rst_n = 1'b0;
      #1 chk("t6_async", {grant, busy, valid_o, end_o, byte_o, strobe, req_ready}, '0);
      valid[0] = 1'b1; begin_v[0] = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      wait_grant(w);
      chk("t6_fresh_rr", grant, 2'b01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/link_arbiter.md
Name: link_arbiter

Overview:
- Shares the single modem byte link (byte/begin/valid/end toward the loopback/RX side) between NREQ transmit controllers.
- Arbitration is round-robin at message granularity: a requester holds the link from its begin byte to its end byte.
- Replaces the free-running 1-in-4 ready counter with a programmable byte-rate pacer.
- Emits the accepted-beat strobe that drives rx_ctrl valid_i.

Parameters:
NREQ, 2, number of requesting tx_ctrl instances (2..8)
DIV_W, 8, width of byte-period divider
GAP_TICKS, 2, idle byte periods inserted after each message end (0..15)
TIMEOUT_TICKS, 64, stall limit in byte periods (only with LINK_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
div_i  in  DIV_W  byte period minus one, in clk cycles
req_valid_i  in  NREQ  requester i presents a byte
req_begin_i  in  NREQ  byte is the first of a message
req_end_i  in  NREQ  byte is the last of a message
req_byte_i  in  8*NREQ  requester bytes, requester i at [8i+7:8i]
req_ready_o  out  NREQ  one-cycle accept pulse back to requester (tx_ctrl ready_i)
byte_o  out  8  granted byte
begin_o  out  1  granted begin flag
valid_o  out  1  granted valid
end_o  out  1  granted end flag
strobe_o  out  1  accepted beat, one cycle (rx_ctrl valid_i)
grant_o  out  NREQ  one-hot current owner, 0 when none
busy_o  out  1  state != IDLE
clk_req_o  out  1  busy_o | any req_valid_i
abort_o  out  1  one-cycle pulse on timeout release

Behaviour:
- Reset: all outputs 0, state IDLE, rr_ptr=0, divider count=0, gap count=0.
- Tick generator:
  - cnt increments every cycle.
  - When cnt >= div_i: tick=1 that cycle and cnt<=0. The >= comparison covers div_i lowered mid-count.
  - div_i=0 gives a tick every cycle. The counter free-runs in all states.
- States: IDLE, XFER, GAP.
- IDLE:
  - Candidates are requesters with req_valid_i & req_begin_i.
  - Pick the first candidate searching from rr_ptr upward with wrap. Arbitration is combinational, same cycle.
  - With a candidate present, register grant_o one-hot and go to XFER on the next cycle.
  - Requesters with valid but no begin are ignored (not message-aligned).
- XFER:
  - byte_o/begin_o/end_o/valid_o are muxed combinationally from the granted requester.
  - Beat accepted when tick & req_valid_i[g]. In that cycle req_ready_o[g]=1 and strobe_o=1; no other req_ready_o is ever asserted.
  - Tick with req_valid_i[g]=0: no beat; grant is held (stall).
  - Accepted beat with end=1: rr_ptr<=g+1 mod NREQ. Then go to GAP if GAP_TICKS>0, else IDLE; grant_o clears next cycle.
  - A begin and end in the same beat is a 1-byte message; it is legal.
- GAP:
  - Gap count increments per tick. Leave for IDLE when the count reaches GAP_TICKS-1 on a tick.
  - valid_o=0 and grant_o=0 during GAP.
- Outputs outside XFER: byte_o/begin_o/end_o/valid_o are 0.
- Simultaneous events: a new request during the end beat is not granted until IDLE. Requests arriving in GAP are queued by their held valid and served round-robin from the updated rr_ptr.
- Reset mid-message: link is released immediately and asynchronously; no end_o is emitted. Downstream rx_ctrl shares the reset.

Optional Feature:
- Macro LINK_ARB_TIMEOUT_EN.
- Defined:
  - XFER keeps a stall counter, cleared on every accepted beat and incremented on each tick without one.
  - On reaching TIMEOUT_TICKS: pulse abort_o, advance rr_ptr past g, go to GAP.
- Undefined: no stall counter; abort_o tied 0; a stalled owner holds the link indefinitely.

Decomposition:
- Package link_arb_pkg: state encoding (IDLE/XFER/GAP), default GAP_TICKS/TIMEOUT_TICKS, round-robin search helper function.
- Sub-module link_tick_gen: divider counter with div_i input and tick output, reusable for RX sampling.

Test Plan:
- Single requester, div_i=3, 3-byte message 'A','b','C' → req_ready_o[0] and strobe_o every 4 clk; end_o on 'C'; then 2 ticks of GAP, busy_o=0.
- Both requesters assert begin in the same IDLE cycle after reset → req0 served first. Next message goes to req1 even if req0 re-requests immediately.
- div_i=0, req1 1-byte message (begin=end=1, 0x5A) → strobe_o one cycle later with byte_o=0x5A, grant released, rr_ptr=0.
- Owner drops valid for 5 ticks mid-message → no strobe_o during the stall, grant_o unchanged, transfer resumes; abort_o=0 with TIMEOUT_TICKS=64.
- LINK_ARB_TIMEOUT_EN, TIMEOUT_TICKS=4, owner stalls → abort_o pulse on the 4th empty tick, grant moves to the waiting requester after GAP.
- rst_n asserted mid-XFER → all outputs 0 asynchronously; after release, a fresh arbitration starts at rr_ptr=0.
